ex_mult_unit: RTL and testbench
===============================

EX_MULT_UNIT -- requirements
Module: ex_mult_unit

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  multiply request; the ID/EX isMult output qualified by a valid, unflushed instruction.
REQ-005 func  input  6  ID/EX func field: 6'h18 selects MULT, 6'h19 selects MULTU, any other value is treated as MULTU.
REQ-006 rs_val, rt_val  input  32 each  forwarded operands from the EX operand muxes.
REQ-007 flush  input  1  pipeline flush; aborts any operation in flight.
REQ-008 wr_hi, wr_lo, wr_data  input  1/1/32  MTHI/MTLO write port.
REQ-009 stall  output  1  when high, the pipeline holds ID/EX and earlier stages (drives en_reg low).
REQ-010 busy  output  1  high while an operation is accepted or running.
REQ-011 done  output  1  single-cycle pulse when a result is committed.
REQ-012 hi, lo  output  32 each  architectural HI/LO registers, read by the EX MFHI/MFLO mux.

Function
REQ-013 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 and flush=0: latch operand magnitudes and the result-sign flag, clear the 64-bit accumulator, clear the 5-bit counter, go to RUN.
REQ-015 RUN: one radix-2 shift-add iteration per cycle, with the counter incrementing each cycle; on the edge when counter=31, write the sign-corrected 64-bit product to {hi,lo} and go to DONE.
REQ-016 DONE: done=1 for exactly this cycle; go to IDLE unconditionally; start is ignored in this cycle.
REQ-017 stall SHALL be combinational: high when (IDLE and start and not flush) or RUN; low in DONE.
REQ-018 Stall therefore lasts 33 cycles (the start cycle plus 32 RUN cycles); the result is visible on hi/lo in the DONE cycle.
REQ-019 busy SHALL be high in RUN and DONE.
REQ-020 MULTU: 32x32 unsigned product, exact to 64 bits; no overflow or truncation.
REQ-021 MULT: operate on magnitudes and negate the 64-bit product when the operand signs differ; 0x80000000 has magnitude 0x80000000, treated as unsigned.
REQ-022 wr_hi/wr_lo SHALL update hi/lo on the clock edge only in IDLE with start=0; they are ignored in any other state or when start=1.
REQ-023 flush in RUN or DONE: return to IDLE next edge; hi/lo unchanged unless already committed; no done pulse.
REQ-024 flush and start together in IDLE: flush wins, no operation starts, stall=0.
REQ-025 The counter SHALL NOT wrap; the transition to DONE occurs at counter=31.

Reset
REQ-026 On rst low, immediately: state=IDLE, counter=0, accumulator=0, hi=0, lo=0.
REQ-027 Reset values while rst is low: stall=0, busy=0, done=0.
REQ-028 Reset asserted mid-RUN SHALL discard the operation; there is no partial commit.

Configuration
REQ-029 Macro MULT_SIGNED_EN SHALL control signed multiply support.
REQ-030 With MULT_SIGNED_EN defined: func 6'h18 performs signed multiply per REQ-021.
REQ-031 Without MULT_SIGNED_EN: sign logic is removed and all requests, including func 6'h18, are unsigned; timing is identical.

Structure
REQ-032 The shared package pipe_pkg SHALL hold FUNC_MULT and FUNC_MULTU constants, the FSM state encoding, and MULT_ITER=32.
REQ-033 The block SHALL be a single module; no sub-module is warranted (datapath is accumulator, shifter, and negator).

Verification
REQ-034 MULTU 3 x 5: stall high for 33 cycles, done pulse, hi=0x00000000, lo=0x0000000F.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 MULT 0xFFFFFFFE x 3 with the macro: hi=0xFFFFFFFF, lo=0xFFFFFFFA; without the macro: hi=0x00000002, lo=0xFFFFFFFA.
REQ-037 MULT 0x80000000 x 0x80000000 with the macro: hi=0x40000000, lo=0x00000000.
REQ-038 Preload hi=0x1234 via wr_hi, start MULTU 7 x 9, flush on RUN cycle 10: state returns to IDLE, no done pulse, hi=0x1234 retained; then rst low on RUN cycle 5 of a second operation: all outputs 0.
REQ-039 wr_hi with start=1 in IDLE: write ignored, multiply proceeds, result overwrites hi/lo.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline constants. Holds the ID/EX func codes that
//               select MULT/MULTU, the iteration count of the sequential
//               multiplier, the multiplier FSM state encoding and a small
//               two's-complement magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // ID/EX func field codes for the multiply instructions
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;

  // One radix-2 iteration per operand bit
  localparam int MULT_ITER = 32;
  localparam int CNT_W     = $clog2(MULT_ITER);

  // Counter value on which the final iteration runs and the result commits
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_ITER - 1);

  // Multiplier FSM encoding (explicit 2-bit width)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  // Magnitude of a two's-complement word. 0x80000000 maps onto itself,
  // which is the correct magnitude when read back as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_mult_unit
// Description : Sequential 32x32 -> 64 multiplier for the EX stage, owning
//               the architectural HI/LO registers. A request taken in IDLE
//               runs 32 radix-2 shift-add iterations, commits the product to
//               {hi,lo}, then pulses done for one cycle. The pipeline is
//               stalled from the start cycle through the last RUN cycle.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   MULT_SIGNED_EN  defined   : func 6'h18 (MULT) performs a signed multiply
//                   undefined : every request is an unsigned multiply
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-low reset
//   start    in   1   multiply request (qualified ID/EX isMult)
//   func     in   6   ID/EX func field (6'h18 MULT, otherwise MULTU)
//   rs_val   in  32   forwarded rs operand
//   rt_val   in  32   forwarded rt operand
//   flush    in   1   pipeline flush, aborts any operation in flight
//   wr_hi    in   1   MTHI write enable
//   wr_lo    in   1   MTLO write enable
//   wr_data  in  32   MTHI/MTLO write data
//   stall    out  1   hold ID/EX and earlier stages
//   busy     out  1   operation running or completing
//   done     out  1   one-cycle pulse when the product is committed
//   hi       out 32   architectural HI
//   lo       out 32   architectural LO
// ============================================================================
module ex_mult_unit
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  func,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  mult_state_e       r_state;
  mult_state_e       w_next_state;

  logic [CNT_W-1:0]  r_cnt;      // iteration counter, saturates at CNT_LAST
  logic [63:0]       r_acc;      // partial-product accumulator
  logic [63:0]       r_mcand;    // multiplicand magnitude, shifted left
  logic [31:0]       r_mplier;   // multiplier magnitude, shifted right
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic w_accept;   // IDLE request that actually starts an operation
  logic w_iter;     // a shift-add iteration happens this cycle
  logic w_commit;   // final iteration: write product to HI/LO
  logic w_mt_ok;    // MTHI/MTLO window

  assign w_accept = (r_state == ST_IDLE) && start && !flush;
  assign w_iter   = (r_state == ST_RUN) && !flush;
  assign w_commit = w_iter && (r_cnt == CNT_LAST);
  assign w_mt_ok  = (r_state == ST_IDLE) && !start;

  // --------------------------------------------------------------------------
  // Operand conditioning
  // --------------------------------------------------------------------------
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;

`ifdef MULT_SIGNED_EN
  logic w_signed_op;
  logic w_neg;      // product sign differs from the magnitude product
  logic r_neg;

  assign w_signed_op = (func == FUNC_MULT);
  assign w_mag_a     = w_signed_op ? mag32(rs_val) : rs_val;
  assign w_mag_b     = w_signed_op ? mag32(rt_val) : rt_val;
  assign w_neg       = w_signed_op && (rs_val[31] ^ rt_val[31]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_neg;
    end
  end
`else
  // Every request is unsigned, so func carries no information here.
  logic w_unused_func;

  assign w_mag_a       = rs_val;
  assign w_mag_b       = rt_val;
  assign w_unused_func = ^func;
`endif

  // --------------------------------------------------------------------------
  // Shift-add datapath
  // --------------------------------------------------------------------------
  logic [63:0] w_addend;
  logic [63:0] w_acc_sum;
  logic [63:0] w_product;

  assign w_addend  = r_mplier[0] ? r_mcand : 64'd0;
  assign w_acc_sum = r_acc + w_addend;

`ifdef MULT_SIGNED_EN
  // The accumulator holds the magnitude product; restore the sign on commit.
  assign w_product = r_neg ? (~w_acc_sum + 64'd1) : w_acc_sum;
`else
  assign w_product = w_acc_sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc    <= 64'd0;
      r_mcand  <= {32'd0, w_mag_a};
      r_mplier <= w_mag_b;
    end else if (w_iter) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      // The last iteration leaves the FSM, so the counter never wraps.
      if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Architectural HI/LO. The commit and the MTHI/MTLO window are mutually
  // exclusive by state, so the priority below never actually resolves a clash.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= w_product[63:32];
      r_lo <= w_product[31:0];
    end else if (w_mt_ok) begin
      if (wr_hi) begin
        r_hi <= wr_data;
      end
      if (wr_lo) begin
        r_lo <= wr_data;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // stall is combinational on start; qualify with rst so it stays low
        // for the whole time reset is held.
        if (start && !flush) begin
          w_next_state = ST_RUN;
          stall        = rst;
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (flush) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mult_unit
// Description : Self-checking bench for ex_mult_unit. Directed vector table,
//               randomized operations against an arithmetic reference model,
//               and hand-written flush / reset / MTHI sequences.
//               Expected values follow MULT_SIGNED_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mult_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  func;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mult_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .func    (func),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .flush   (flush),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact 64-bit product from plain arithmetic.
  function automatic logic [63:0] ref_mul(input logic [5:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
`ifdef MULT_SIGNED_EN
    if (f == 6'h18) return 64'(sa * sb);
`endif
    if (sa == sb) begin end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation and follow it to completion.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; func = f; rs_val = a; rt_val = b;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      // operands must have been latched; scramble the buses
      start = 1'b0; func = 6'($urandom); rs_val = $urandom; rt_val = $urandom;
      #1;
    end
    check({nm, " stall_len"}, 64'(n), 64'd33);
    check({nm, " done"}, {63'd0, done}, 64'd1);
    check({nm, " busy_done"}, {63'd0, busy}, 64'd1);
    check({nm, " result"}, {hi, lo}, exp);
    @(negedge clk);
    #1;
    check({nm, " done_single"}, {62'd0, done, busy}, 64'd0);
  endtask

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          saw_done;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rf;

    vecs[0] = '{6'h19, 32'd3,         32'd5,         64'h00000000_0000000F, "multu_3x5"};
    vecs[1] = '{6'h19, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001, "multu_max"};
    vecs[3] = '{6'h18, 32'h80000000,  32'h80000000,  64'h40000000_00000000, "mult_minint"};
    vecs[4] = '{6'h3F, 32'h00010000,  32'h00010000,  64'h00000001_00000000, "other_func"};
    vecs[5] = '{6'h19, 32'd0,         32'hDEADBEEF,  64'h0,                 "zero"};
`ifdef MULT_SIGNED_EN
    vecs[2] = '{6'h18, 32'hFFFFFFFE,  32'd3,         64'hFFFFFFFF_FFFFFFFA, "mult_neg2x3"};
    vecs[6] = '{6'h18, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001, "mult_m1xm1"};
    vecs[7] = '{6'h18, 32'd7,         32'hFFFFFFFE,  64'hFFFFFFFF_FFFFFFF2, "mult_7xm2"};
`else
    vecs[2] = '{6'h18, 32'hFFFFFFFE,  32'd3,         64'h00000002_FFFFFFFA, "mult_neg2x3"};
    vecs[6] = '{6'h18, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001, "mult_m1xm1"};
    vecs[7] = '{6'h18, 32'd7,         32'hFFFFFFFE,  64'h00000006_FFFFFFF2, "mult_7xm2"};
`endif

    rst = 1'b1; start = 1'b0; func = 6'h19; rs_val = 0; rt_val = 0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 0;

    // Reset, with a pending request that must not raise stall
    #2 rst = 1'b0;
    start = 1'b1; rs_val = 32'd9; rt_val = 32'd9;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {29'd0, stall, busy, done, hi, lo}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

    // Randomized operations against the reference model
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0: rf = 6'h18;
        1: rf = 6'h19;
        default: rf = 6'($urandom);
      endcase
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(0, 3));
      run_op(rf, ra, rb, ref_mul(rf, ra, rb), $sformatf("rand%0d", k));
    end

    // MTHI / MTLO in IDLE
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h00005A5A;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    #1;
    check("mthi_mtlo", {hi, lo}, 64'h00005A5A_00005A5A);

    // flush together with start: flush wins, write also ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; wr_hi = 1'b1; wr_data = 32'hBAD0BAD0;
    #1;
    check("flush_start_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0; wr_hi = 1'b0;
    #1;
    check("flush_start_idle", {63'd0, busy}, 64'd0);
    check("flush_start_hi", {32'd0, hi}, 64'h00005A5A);

    // Preload HI, start 7x9, flush on RUN cycle 10
    wr_hi = 1'b1; wr_data = 32'h00001234;
    @(negedge clk);
    wr_hi = 1'b0;
    #1;
    check("preload_hi", {32'd0, hi}, 64'h1234);
    @(negedge clk);
    start = 1'b1; func = 6'h19; rs_val = 32'd7; rt_val = 32'd9;
    @(negedge clk);             // RUN cycle 1
    start = 1'b0;
    repeat (9) @(negedge clk);  // RUN cycle 10
    #1;
    check("run_busy", {62'd0, busy, stall}, 64'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", {61'd0, stall, busy, done}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", {63'd0, saw_done}, 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h00001234_00005A5A);

    // Second op, reset on RUN cycle 5
    @(negedge clk);
    start = 1'b1; func = 6'h19; rs_val = 32'd7; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun_reset", {29'd0, stall, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("reset_discard", {31'd0, saw_done, hi, lo}, 64'd0);

    // MTHI with start=1 is ignored; the multiply runs and overwrites
    @(negedge clk);
    start = 1'b1; func = 6'h19; rs_val = 32'd6; rt_val = 32'd7;
    wr_hi = 1'b1; wr_data = 32'hAAAA5555;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    #1;
    check("mthi_with_start", {32'd0, hi}, 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 100 && !saw_done; c++) begin
      @(negedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("mthi_start_done", {63'd0, saw_done}, 64'd1);
    check("mthi_start_result", {hi, lo}, 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
